regfile_sb: RTL and testbench

- Parametrised successor to the core's integer register file.
- Provides NRD combinational read ports, NWR write ports, and x0 hardwired to zero.
- Adds one-cycle-delayed registered copies of every read port, and a per-register busy scoreboard.
- The issue stage uses the scoreboard to detect RAW hazards against in-flight writebacks.
- Sits between decode/issue and the writeback stage.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 78 +++++++
 tb/tb_regfile_sb.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the integer register file with scoreboard.
// Optional build macro: REGFILE_BYPASS_EN (write-to-read bypass).
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xword_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_sb_if.sv
// Issue/writeback bus of the register file: read ports, write ports, reserve
// request and scoreboard outputs. Optional build macro: REGFILE_BYPASS_EN.
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int AW = $clog2(NREGS);

  // No flow control: there is no valid/ready pair; every read, write and
  // reserve presented in a cycle is accepted on that cycle's rising edge.
  logic [NRD*AW-1:0]   ar_i;
  logic [NRD*XLEN-1:0] r_o;
  logic [NRD*XLEN-1:0] rd_o;
  logic [NRD-1:0]      busy_o;
  logic [NWR*AW-1:0]   aw_i;
  logic [NWR*XLEN-1:0] wd_i;
  logic [NWR-1:0]      we_i;
  logic                rsv_i;
  logic [AW-1:0]       rsv_addr_i;
  logic [NREGS-1:0]    busy_all_o;

  modport master (
    output ar_i, aw_i, wd_i, we_i, rsv_i, rsv_addr_i,
    input  r_o, rd_o, busy_o, busy_all_o
  );

  modport slave (
    input  ar_i, aw_i, wd_i, we_i, rsv_i, rsv_addr_i,
    output r_o, rd_o, busy_o, busy_all_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reserve sets, writeback clears, x0 never busy.
// Optional build macro: REGFILE_BYPASS_EN masks busy on same-cycle writes.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] ar,
  input  logic [NWR*AW-1:0] aw,
  input  logic [NWR-1:0]    we,
  input  logic              rsv,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NRD-1:0]    busy_rd,
  output logic [NREGS-1:0]  busy_all
);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Reserve is applied after the clears so a newer producer keeps the bit set.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NWR; w++) begin
      if (we[w]) busy_nxt[aw[w*AW +: AW]] = 1'b0;
    end
    if (rsv && (rsv_addr != ZERO)) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_nxt;
  end

  assign busy_all = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_lookup
    logic [AW-1:0] ra;
    logic          b;
    assign ra = ar[k*AW +: AW];
    always_comb begin
      b = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (we[w] && (aw[w*AW +: AW] == ra) && (ra != ZERO)) b = 1'b0;
      end
`endif
    end
    assign busy_rd[k] = b;
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file: NRD comb read ports, registered read copies,
// NWR write ports, x0 = 0, plus busy scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0]     regs [NREGS];
  logic [XLEN-1:0]     rdata [NRD];
  logic [NRD*XLEN-1:0] r_pack;
  logic [NRD*XLEN-1:0] rd_q;

  // Later write ports are assigned last, so port NWR-1 wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.we_i[w] && (bus.aw_i[w*AW +: AW] != ZERO))
          regs[bus.aw_i[w*AW +: AW]] <= bus.wd_i[w*XLEN +: XLEN];
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_read
    logic [AW-1:0] ra;
    assign ra = bus.ar_i[k*AW +: AW];
    always_comb begin
      rdata[k] = (ra == ZERO) ? '0 : regs[ra];
`ifdef REGFILE_BYPASS_EN
      for (int w = 0; w < NWR; w++) begin
        if (bus.we_i[w] && (bus.aw_i[w*AW +: AW] == ra) && (ra != ZERO))
          rdata[k] = bus.wd_i[w*XLEN +: XLEN];
      end
`endif
    end
  end

  always_comb begin
    r_pack = '0;
    for (int k = 0; k < NRD; k++) r_pack[k*XLEN +: XLEN] = rdata[k];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= r_pack;
  end

  assign bus.r_o  = r_pack;
  assign bus.rd_o = rd_q;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .ar       (bus.ar_i),
    .aw       (bus.aw_i),
    .we       (bus.we_i),
    .rsv      (bus.rsv_i),
    .rsv_addr (bus.rsv_addr_i),
    .busy_rd  (bus.busy_o),
    .busy_all (bus.busy_all_o)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (NRD=2, NWR=2); expectations follow
// REGFILE_BYPASS_EN when the build defines it.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  xword_t exp_reg [NREGS];
  xword_t prev0, prev1, e0, e1;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ar_i       = '0;
    bus.aw_i       = '0;
    bus.wd_i       = '0;
    bus.we_i       = '0;
    bus.rsv_i      = 1'b0;
    bus.rsv_addr_i = '0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    bus.ar_i[4:0] = a0[4:0];
    bus.ar_i[9:5] = a1[4:0];
  endtask

  task automatic set_wr(input int p, input int a, input xword_t d);
    bus.aw_i[p*5 +: 5]  = a[4:0];
    bus.wd_i[p*32 +: 32] = d;
    bus.we_i[p]          = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic xword_t r(input int k);
    return bus.r_o[k*32 +: 32];
  endfunction

  function automatic xword_t rd(input int k);
    return bus.rd_o[k*32 +: 32];
  endfunction

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < NREGS; i++) exp_reg[i] = '0;
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state: every address reads zero, nothing busy
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i, NREGS - 1 - i);
      #1;
      chk("rst_r0", r(0), 32'd0);
      chk("rst_r1", r(1), 32'd0);
      chk("rst_rd0", rd(0), 32'd0);
      chk("rst_busy_all", bus.busy_all_o, 32'd0);
      tick();
    end

    // fill reg i <- 2i+3 (x0 write ignored)
    idle();
    for (int i = 0; i < NREGS; i++) begin
      set_wr(0, i, xword_t'(2 * i + 3));
      if (i != 0) exp_reg[i] = xword_t'(2 * i + 3);
      tick();
    end
    idle();

    // read back: ar0=i, ar1=2i mod 32; rd_o lags r_o by one cycle
    prev0 = '0;
    prev1 = '0;
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i, (2 * i) % NREGS);
      e0 = exp_reg[i];
      e1 = exp_reg[(2 * i) % NREGS];
      #1;
      chk("fill_r0", r(0), e0);
      chk("fill_r1", r(1), e1);
      chk("fill_rd0", rd(0), prev0);
      chk("fill_rd1", rd(1), prev1);
      prev0 = e0;
      prev1 = e1;
      tick();
    end
    chk("x0_reads_zero", exp_reg[0] | r(0) & 32'd0, 32'd0);

    // same-cycle read of a write to x5
    idle();
    set_rd(5, 0);
    set_wr(0, 5, 32'hDEAD_BEEF);
    #1;
    chk("byp_same_cycle", r(0), BYP ? 32'hDEAD_BEEF : 32'd13);
    exp_reg[5] = 32'hDEAD_BEEF;
    tick();
    bus.we_i = '0;
    #1;
    chk("byp_next_cycle", r(0), 32'hDEAD_BEEF);
    chk("byp_rd_latency", rd(0), BYP ? 32'hDEAD_BEEF : 32'd13);
    tick();

    // scoreboard lifecycle on x7
    idle();
    set_rd(7, 0);
    bus.rsv_i      = 1'b1;
    bus.rsv_addr_i = 5'd7;
    #1;
    chk("sb_before_rsv", {31'd0, bus.busy_o[0]}, 32'd0);
    tick();
    bus.rsv_i = 1'b0;
    #1;
    chk("sb_rsv_all", bus.busy_all_o, 32'h0000_0080);
    chk("sb_rsv_busy_o", {31'd0, bus.busy_o[0]}, 32'd1);
    chk("sb_rsv_busy_o1", {31'd0, bus.busy_o[1]}, 32'd0);
    set_wr(0, 7, 32'h0000_0077);
    exp_reg[7] = 32'h0000_0077;
    #1;
    chk("sb_wr_mask", {31'd0, bus.busy_o[0]}, BYP ? 32'd0 : 32'd1);
    tick();
    bus.we_i = '0;
    #1;
    chk("sb_wr_clear", bus.busy_all_o, 32'd0);
    chk("sb_wr_data", r(0), 32'h0000_0077);
    bus.rsv_i      = 1'b1;
    bus.rsv_addr_i = 5'd7;
    set_wr(0, 7, 32'h0000_0088);
    exp_reg[7] = 32'h0000_0088;
    tick();
    idle();
    set_rd(7, 0);
    #1;
    chk("sb_rsv_wr_same", bus.busy_all_o, 32'h0000_0080);
    chk("sb_rsv_wr_data", r(0), 32'h0000_0088);
    bus.rsv_i      = 1'b1;
    bus.rsv_addr_i = 5'd7;
    tick();
    bus.rsv_addr_i = 5'd0;
    tick();
    bus.rsv_i = 1'b0;
    #1;
    chk("sb_rsv_twice_rsv0", bus.busy_all_o, 32'h0000_0080);
    chk("sb_x0_busy_o", {31'd0, bus.busy_o[1]}, 32'd0);

    // dual write collision on x9: port 1 wins
    idle();
    set_rd(9, 0);
    set_wr(0, 9, 32'd1);
    set_wr(1, 9, 32'd2);
    #1;
    chk("dual_same_cycle", r(0), BYP ? 32'd2 : 32'd21);
    exp_reg[9] = 32'd2;
    tick();
    bus.we_i = '0;
    #1;
    chk("dual_port1_wins", r(0), 32'd2);
    set_wr(0, 0, 32'hFFFF_FFFF);
    set_rd(9, 0);
    #1;
    chk("x0_write_same", r(1), 32'd0);
    tick();
    bus.we_i = '0;
    #1;
    chk("x0_write_ignored", r(1), 32'd0);

    // reset in the same cycle as a reserve and a write to x4
    idle();
    bus.rsv_i      = 1'b1;
    bus.rsv_addr_i = 5'd4;
    set_wr(0, 4, 32'd55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    set_rd(4, 9);
    #1;
    chk("mid_rst_reg4", r(0), 32'd0);
    chk("mid_rst_reg9", r(1), 32'd0);
    chk("mid_rst_busy", bus.busy_all_o, 32'd0);
    chk("mid_rst_rd", rd(0), 32'd0);
    tick();
    #1;
    chk("post_rst_rd", rd(1), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, observed %0d/%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end
endmodule
